// File: rtl/fft_pkg.sv
// Shared definitions for the single-path delay-feedback FFT stages:
// transform size, sample width, stage sequencer states and delay-line sizing.
package fft_pkg;

  localparam int FFT_N      = 128;
  localparam int LOG2_N     = $clog2(FFT_N);
  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } sdf_state_t;

  // Delay-line depth of a radix-2 SDF stage in the default-size transform
  function automatic int sdf_delay(input int stage);
    return FFT_N >> (stage + 1);
  endfunction

endpackage

// File: rtl/sdf_frame_counter.sv
// Modulo-2*DELAY sample counter for one SDF stage. phase marks the second
// half of the frame (butterfly half); idx is the position within the half.
module sdf_frame_counter #(
  parameter  int DELAY = 64,
  localparam int CW    = $clog2(2 * DELAY),
  localparam int IW    = (DELAY > 1) ? $clog2(DELAY) : 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          phase,
  output logic [IW-1:0] idx
);

  // Count accepted samples / drain cycles; the power-of-two width gives the wrap for free
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign phase = cnt[CW-1];

  if (DELAY > 1) begin : g_idx
    assign idx = cnt[IW-1:0];
  end else begin : g_idx_unit
    assign idx = 1'b0;
  end

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Per-stage sequencer for a radix-2 SDF FFT stage: drives butterfly enable,
// delay-line shift/write-select, output mux and twiddle address, frames the
// stage output with valid/start-of-frame, and drains the last frame's
// differences on request. All outputs are registered one cycle after the
// sample or drain cycle they describe.
// Optional build macro SDF_CTRL_ERR_EN: enables the sticky protocol checker
// driving err; without it err is tied low.
module sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter  int N     = 128,
  parameter  int STAGE = 0,
  localparam int TW_W  = $clog2(N / 2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_sop,
  input  logic            flush,
  output logic            bf_en,
  output logic            dl_shift,
  output logic            dl_sel,
  output logic            out_sel,
  output logic [TW_W-1:0] tw_addr,
  output logic            out_valid,
  output logic            out_sop,
  output logic            busy,
  output logic            err
);

  localparam int DELAY = N >> (STAGE + 1);
  localparam int CW    = $clog2(2 * DELAY);
  localparam int IW    = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CW-1:0] CNT_LAST_FILL = CW'(DELAY - 1);
  localparam logic [CW-1:0] CNT_FIRST_SUM = CW'(DELAY);

  sdf_state_t      state;
  logic            flush_pend;
  logic [CW-1:0]   cnt;
  logic            phase;
  logic [IW-1:0]   idx;
  logic            accept;
  logic            drain;
  logic            at_last_fill;
  logic            cnt_en;
  logic            cnt_clr;
  logic [TW_W-1:0] tw_next;

  // Decode which samples are taken and when the counter moves
  always_comb begin
    accept       = in_valid && ((state == FILL) || (state == RUN) ||
                                ((state == IDLE) && in_sop));
    drain        = (state == FLUSH);
    at_last_fill = (cnt == CNT_LAST_FILL);
    cnt_en       = accept || drain;
    cnt_clr      = rst || (drain && at_last_fill);
  end

  assign tw_next = TW_W'(idx) << STAGE;

  sdf_frame_counter #(
    .DELAY (DELAY)
  ) u_cnt (
    .clk   (clk),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt),
    .phase (phase),
    .idx   (idx)
  );

  // Stage sequencing; a flush request waits for a gap at the frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_sop) begin
            state <= at_last_fill ? RUN : FILL;
          end
        end
        FILL: begin
          if (accept && at_last_fill) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!in_valid && (cnt == '0) && (flush_pend || flush)) begin
            state      <= FLUSH;
            flush_pend <= 1'b0;
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        FLUSH: begin
          if (at_last_fill) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: strobes describing the sample accepted (or drain cycle) one clock earlier
  always_ff @(posedge clk) begin
    if (rst) begin
      bf_en     <= 1'b0;
      dl_shift  <= 1'b0;
      dl_sel    <= 1'b0;
      out_sel   <= 1'b0;
      tw_addr   <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      bf_en     <= accept && phase;
      dl_sel    <= accept && phase;
      out_sel   <= accept && phase;
      dl_shift  <= cnt_en;
      out_valid <= (accept && (phase || (state == RUN))) || drain;
      out_sop   <= accept && (cnt == CNT_FIRST_SUM);
      tw_addr   <= ((accept && !phase && (state == RUN)) || drain) ? tw_next : '0;
      busy      <= (state != IDLE);
    end
  end

`ifdef SDF_CTRL_ERR_EN
  logic proto_bad;

  // Misplaced start-of-frame, samples during drain, or a stream with no start marker
  always_comb begin
    proto_bad = in_valid &&
                ((((state == FILL) || (state == RUN)) && in_sop && (cnt != '0)) ||
                 (state == FLUSH) ||
                 ((state == IDLE) && !in_sop));
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (proto_bad) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Scoreboard bench for sdf_stage_ctrl: three stages (0, 1, 6) of a 128-point
// transform share one randomized stimulus stream; a frame-level reference
// model predicts every output sample and the per-cycle control strobes.
module tb_sdf_stage_ctrl;

  localparam int N    = 128;
  localparam int TW_W = 6;
  localparam int STG [3] = '{0, 1, 6};

`ifdef SDF_CTRL_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  typedef struct {
    int inst;
    int due;
    bit sop;
    bit osel;
    bit bf;
    bit dsel;
    int tw;
  } exp_t;

  typedef struct {
    int d;
    int stg;
    bit running;
    int n;
    bit flush_req;
    int drain_left;
    bit err;
  } mdl_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_sop, flush;
  logic bf_en [3];
  logic dl_shift [3];
  logic dl_sel [3];
  logic out_sel [3];
  logic out_valid [3];
  logic out_sop [3];
  logic busy [3];
  logic err [3];
  logic [TW_W-1:0] tw_addr [3];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;
  exp_t sb[$];
  mdl_t m [3];
  logic [2:0] ctl_exp [3][4];
  int ctl_due [3][4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sdf_stage_ctrl #(.N(N), .STAGE(STG[g])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sop    (in_sop),
      .flush     (flush),
      .bf_en     (bf_en[g]),
      .dl_shift  (dl_shift[g]),
      .dl_sel    (dl_sel[g]),
      .out_sel   (out_sel[g]),
      .tw_addr   (tw_addr[g]),
      .out_valid (out_valid[g]),
      .out_sop   (out_sop[g]),
      .busy      (busy[g]),
      .err       (err[g])
    );
  end

  function automatic void push(int g, bit s, bit sum, int tw);
    exp_t e;
    e.inst = g;
    e.due  = cyc + 1;
    e.sop  = s;
    e.osel = sum;
    e.bf   = sum;
    e.dsel = sum;
    e.tw   = tw;
    sb.push_back(e);
  endfunction

  // One sample of the frame: first half feeds the delay line (emitting last
  // frame's differences once primed), second half emits butterfly sums.
  function automatic void take(int g);
    int p;
    p = m[g].n % (2 * m[g].d);
    if (p >= m[g].d) push(g, p == m[g].d, 1'b1, 0);
    else if (m[g].n >= m[g].d) push(g, 1'b0, 1'b0, p << m[g].stg);
    m[g].n = m[g].n + 1;
  endfunction

  task automatic step(int g, bit iv, bit sop, bit fl, bit rs);
    bit busy_e, dsh_e, run_st;
    int p, slot;
    busy_e = m[g].running || (m[g].drain_left > 0);
    dsh_e  = 1'b0;
    run_st = m[g].running && (m[g].n >= m[g].d);
    p      = m[g].n % (2 * m[g].d);
    if (rs) begin
      m[g].running = 1'b0;
      m[g].n = 0;
      m[g].flush_req = 1'b0;
      m[g].drain_left = 0;
      m[g].err = 1'b0;
      busy_e = 1'b0;
    end else if (m[g].drain_left > 0) begin
      if (iv && ERR_ON) m[g].err = 1'b1;
      dsh_e = 1'b1;
      push(g, 1'b0, 1'b0, (m[g].d - m[g].drain_left) << m[g].stg);
      m[g].drain_left = m[g].drain_left - 1;
    end else if (!m[g].running) begin
      if (iv && sop) begin
        m[g].running = 1'b1;
        m[g].n = 0;
        dsh_e = 1'b1;
        take(g);
      end else if (iv && ERR_ON) begin
        m[g].err = 1'b1;
      end
    end else if (iv) begin
      if (sop && (p != 0) && ERR_ON) m[g].err = 1'b1;
      if (fl && run_st) m[g].flush_req = 1'b1;
      dsh_e = 1'b1;
      take(g);
    end else if (run_st && (p == 0) && (m[g].flush_req || fl)) begin
      m[g].drain_left = m[g].d;
      m[g].flush_req = 1'b0;
      m[g].running = 1'b0;
    end else if (fl && run_st) begin
      m[g].flush_req = 1'b1;
    end
    slot = (cyc + 1) % 4;
    ctl_due[g][slot] = cyc + 1;
    ctl_exp[g][slot] = {busy_e, m[g].err, dsh_e};
  endtask

  task automatic drive(bit iv, bit sop, bit fl, bit rs);
    @(posedge clk);
    #1;
    in_valid = iv;
    in_sop   = sop;
    flush    = fl;
    rst      = rs;
    for (int g = 0; g < 3; g++) step(g, iv, sop, fl, rs);
    mon_on = 1'b1;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(int gap_pct, int fl_at, int sop2_at, int rst_at);
    int s;
    s = 0;
    while (s < 128) begin
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        drive(1'b1, (s == 0) || (s == sop2_at), s == fl_at, s == rst_at);
        if (s == rst_at) break;
        s++;
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    int i, hit, slot;
    if (mon_on) begin
      for (int g = 0; g < 3; g++) begin
        i = 0;
        while (i < sb.size()) begin
          if ((sb[i].inst == g) && (sb[i].due < cyc)) begin
            checks++;
            errors++;
            $display("FAIL missing_out inst=%0d cyc=%0d got no output, want output due at %0d",
                     g, cyc, sb[i].due);
            sb.delete(i);
          end else begin
            i++;
          end
        end
        hit = -1;
        for (int j = 0; j < sb.size(); j++)
          if ((hit < 0) && (sb[j].inst == g) && (sb[j].due == cyc)) hit = j;
        checks++;
        if (out_valid[g] === 1'b1) begin
          if (hit < 0) begin
            errors++;
            $display("FAIL unexpected_out inst=%0d cyc=%0d got out_valid=1 want 0", g, cyc);
          end else begin
            if ((out_sop[g] !== sb[hit].sop) || (out_sel[g] !== sb[hit].osel) ||
                (bf_en[g] !== sb[hit].bf) || (dl_sel[g] !== sb[hit].dsel) ||
                (tw_addr[g] !== TW_W'(sb[hit].tw))) begin
              errors++;
              $display("FAIL out_data inst=%0d cyc=%0d got sop=%b sel=%b bf=%b dsel=%b tw=%0d want sop=%b sel=%b bf=%b dsel=%b tw=%0d",
                       g, cyc, out_sop[g], out_sel[g], bf_en[g], dl_sel[g], tw_addr[g],
                       sb[hit].sop, sb[hit].osel, sb[hit].bf, sb[hit].dsel, sb[hit].tw);
            end
            sb.delete(hit);
          end
        end else if (hit >= 0) begin
          errors++;
          $display("FAIL missing_out inst=%0d cyc=%0d got out_valid=%b want 1", g, cyc, out_valid[g]);
          sb.delete(hit);
        end else if (({out_sop[g], out_sel[g], bf_en[g], dl_sel[g]} !== 4'b0000) ||
                     (tw_addr[g] !== '0)) begin
          errors++;
          $display("FAIL quiet_out inst=%0d cyc=%0d got sop=%b sel=%b bf=%b dsel=%b tw=%0d want all 0",
                   g, cyc, out_sop[g], out_sel[g], bf_en[g], dl_sel[g], tw_addr[g]);
        end
        slot = cyc % 4;
        if (ctl_due[g][slot] == cyc) begin
          checks++;
          if ({busy[g], err[g], dl_shift[g]} !== ctl_exp[g][slot]) begin
            errors++;
            $display("FAIL ctl inst=%0d cyc=%0d got busy/err/shift=%b want %b",
                     g, cyc, {busy[g], err[g], dl_shift[g]}, ctl_exp[g][slot]);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_sop = 1'b0;
    flush = 1'b0;
    for (int g = 0; g < 3; g++) begin
      m[g].d = N >> (STG[g] + 1);
      m[g].stg = STG[g];
      m[g].running = 1'b0;
      m[g].n = 0;
      m[g].flush_req = 1'b0;
      m[g].drain_left = 0;
      m[g].err = 1'b0;
      for (int s = 0; s < 4; s++) ctl_due[g][s] = -1;
    end
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // contiguous frame, flush at the boundary, full drain
    frame(0, -1, -1, -1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(70);
    // gapped frames; flush raised mid-frame at count 10 of the second one
    frame(30, -1, -1, -1);
    idle(70);
    frame(30, 10, -1, -1);
    idle(70);
    // reset in the middle of a frame, then stray samples without a start marker
    frame(0, -1, -1, 40);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    // restart with a misplaced start-of-frame at count 5
    frame(0, -1, 5, -1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(70);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover_outputs got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdf_stage_ctrl.md
# sdf_stage_ctrl

Per-stage sequencer for the 128-point single-path delay-feedback (SDF) FFT. One instance sits beside each radix-2 stage and drives that stage's butterfly enable, delay-line shift and write-select, output mux and twiddle ROM address from a streaming sample count. It also frames the stage output with valid and start-of-frame strobes, and provides a flush sequence that drains the last frame's differences.

## Interface
- `N`, 128, FFT length (power of two, ≥ 4)
- `STAGE`, 0, stage index 0..log2(N)-1; `DELAY = N >> (STAGE+1)`
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  one input sample present this cycle
- `in_sop`  in  1  first sample of a frame (qualified by `in_valid`)
- `flush`  in  1  pulse: drain pending differences after the current frame
- `bf_en`  out  1  butterfly enable
- `dl_shift`  out  1  delay line advances one entry
- `dl_sel`  out  1  delay-line write source: 0 = stage input, 1 = butterfly difference
- `out_sel`  out  1  stage output source: 0 = twiddled delay-line head, 1 = butterfly sum
- `tw_addr`  out  log2(N/2)  twiddle ROM address
- `out_valid`  out  1  stage output sample valid
- `out_sop`  out  1  first output sample of a frame
- `busy`  out  1  state ≠ IDLE
- `err`  out  1  sticky protocol error (see Configuration)

## Operation
- Frame counter `cnt`, width log2(2·DELAY). It advances on each accepted `in_valid`, and once per cycle in FLUSH. It wraps from 2·DELAY-1 to 0. `phase = (cnt ≥ DELAY)`.
- FSM states:
  - IDLE → FILL on `in_valid && in_sop`.
  - FILL → RUN on the accepted sample with `cnt == DELAY-1`.
  - RUN → FLUSH at frame boundary (`cnt == 0`, no `in_valid` this cycle) when flush is pending.
  - FLUSH → IDLE after DELAY drain cycles.
- `flush` arriving mid-frame is latched in `flush_pend` and taken at the next boundary. `flush` in IDLE or FILL is ignored. `flush_pend` is cleared on entry to FLUSH.
- Per accepted sample:
  - Phase 0: `bf_en=0`, `dl_sel=0`, `out_sel=0`, `dl_shift=1`. The input enters the delay line. The head of the delay line, holding the previous frame's difference, is output.
  - Phase 1: `bf_en=1`, `dl_sel=1`, `out_sel=1`, `dl_shift=1`. The sum is output and the difference is written to the delay line.
- `out_valid`:
  - Phase 1 in FILL/RUN: 1.
  - Phase 0 in RUN and every FLUSH cycle: 1.
  - FILL phase 0: 0, since nothing is pending.
- `out_sop=1` on the output with `cnt == DELAY`, the first sum of each frame.
- `tw_addr = (cnt mod DELAY) << STAGE` while difference outputs are emitted. It is 0 otherwise.
- FLUSH: `dl_shift=1`, `out_sel=0`, `out_valid=1`, `bf_en=0` each cycle. `in_valid` is ignored.
- `in_sop` is required only to start from IDLE. Afterwards it is checked only, never used to resync.

## Timing
- All outputs are registered. They appear one cycle after the accepted `in_valid` or FLUSH cycle they describe, and the datapath registers its input once to match.
- Reset values:
  - All outputs 0.
  - `cnt` 0, state IDLE, `flush_pend` 0.
- Reset mid-frame: next cycle state is IDLE and pending delay-line data is abandoned. No `out_valid` follows until a new `in_sop`.
- First `out_valid` after IDLE: DELAY accepted samples plus 1 cycle.
- FLUSH lasts exactly DELAY cycles. `busy` falls on the cycle after the last drain output.
- Gaps in `in_valid` freeze `cnt` and all strobes; outputs are 0 during gaps.
- DELAY = 1 (last stage): phases alternate every sample. FILL covers exactly one sample.

## Configuration
- `SDF_CTRL_ERR_EN` defined:
  - `err` sets on `in_sop` with `cnt ≠ 0` in FILL/RUN.
  - `err` sets on `in_valid` during FLUSH.
  - `err` sets on `in_valid` without `in_sop` in IDLE.
  - `err` clears only on `rst`.
  - The offending sample is still processed normally, except in FLUSH where it is dropped.
- `SDF_CTRL_ERR_EN` undefined: checks are not compiled and `err` is tied to 0.

## Structure
- Shared package `fft_pkg`:
  - `FFT_N`, `LOG2_N`, `DATA_WIDTH`
  - state enum `sdf_state_t` (IDLE, FILL, RUN, FLUSH)
  - function `sdf_delay(stage)`
- Sub-module `sdf_frame_counter`: modulo-2·DELAY counter with enable, clear, `phase` and `idx` outputs.

## Test plan
- N=128, STAGE=0: `in_sop` + 128 contiguous valid samples, then `flush` → 64 sums with `out_sop` on the first, then 64 FLUSH outputs with `tw_addr` 0,1,…,63; `busy` low afterwards.
- STAGE=6 (DELAY=1): 4 back-to-back frames → `out_valid` every cycle after the first sample, `out_sop` every 2nd output, `tw_addr` always 0.
- STAGE=1: random `in_valid` gaps → `cnt` frozen during gaps, output count equals input count, `out_sop` spacing equals 64 outputs.
- `flush` pulse at `cnt=10`, STAGE=0 → taken at the frame boundary, FLUSH lasts 64 cycles, no input lost.
- `rst` at `cnt=40` of frame 2 → all outputs 0 the next cycle, state IDLE; new `in_sop` restarts FILL with no stale `out_valid`.
- With `SDF_CTRL_ERR_EN`: `in_sop` at `cnt=5` → `err=1` and stays 1; `cnt` sequence unchanged. Without the macro → `err` stays 0.
